moore_seq_gen: RTL and testbench
================================

# moore_seq_gen

Moore-machine serial pattern generator, the transmit-side counterpart of the serial sequence detectors in the same codebase. On a start request it drives a fixed parameterised bit pattern onto a one-bit serial line, MSB first, one bit per clock. It repeats the pattern a requested number of times, with idle gap cycles between repetitions. It feeds detector blocks in system tests and provides stimulus for their benches.

## Interface
- PAT_W, 4: pattern length in bits (2..16)
- PATTERN, 4'b1011: pattern transmitted MSB first
- GAP, 2: idle cycles between repetitions (0..15; 0 = back-to-back)
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  transmit request, sampled only in IDLE
- cnt  input  4  repetition count, latched with start
- y  output  1  serial data
- valid  output  1  y carries a pattern (or parity) bit
- busy  output  1  transmission in progress
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, SEND, PARITY (only when the parity macro is defined), GAP, DONE. Encoded in 3 bits; the encodings live in the package.
- All outputs are Moore outputs, decoded from state and registers only. No input reaches an output combinationally.
  - IDLE: y=0, valid=0, busy=0, done=0.
  - SEND: y = shift-register MSB, valid=1, busy=1.
  - PARITY: y = even-parity bit of PATTERN, valid=1, busy=1.
  - GAP: y=0, valid=0, busy=1.
  - DONE: done=1, busy=0, valid=0, y=0.
- IDLE with start=1:
  - cnt≠0: load the shift register with PATTERN, load the repetition counter with cnt, reset the bit counter, go to SEND.
  - cnt=0: go directly to DONE; no bits are sent.
- SEND: shift left by one each cycle. After the PAT_W-th bit:
  - go to PARITY if the parity macro is defined;
  - otherwise, go to GAP if repetitions remain and GAP>0;
  - otherwise, go to SEND with the shift register reloaded, if repetitions remain;
  - otherwise, go to DONE.
- PARITY: one cycle, then the same repeat/GAP/DONE decision as at the end of SEND.
- GAP: exactly GAP cycles, then reload PATTERN and go to SEND.
- DONE: one cycle, then IDLE.
- start is ignored in every state other than IDLE. cnt is only read at start acceptance.
- Repetition counter: 4-bit, decremented at the end of each pattern. The "repetitions remain" test is counter>1 before the decrement.
- Reset: when rst goes low, state goes to IDLE and all counters and outputs go to 0 immediately, including mid-transmission. No partial word is resumed after reset is released.

## Timing
- Latency: start accepted at edge N; first bit appears on y after edge N and is valid from cycle N+1.
- Each bit is held for exactly one cycle.
- Total busy cycles = cnt·(PAT_W + P) + (cnt−1)·GAP, where P=1 with parity and P=0 without.
- done is asserted in the cycle after busy falls. A new start is accepted in IDLE, i.e. no earlier than 2 cycles after the last bit.
- cnt=0: done is asserted in cycle N+1; busy and valid never assert.

## Configuration
- MOORE_SEQ_GEN_PARITY_EN defined: the PARITY state exists, and each repetition is followed by one even-parity bit with valid=1.
- Not defined: the PARITY state and its logic are absent, and repetitions carry pattern bits only.

## Structure
- Shared package moore_seq_pkg holds:
  - state encoding localparams (IDLE=000, SEND=001, PARITY=010, GAP=011, DONE=100);
  - default PATTERN/PAT_W/GAP constants;
  - an even-parity function.
- The state register is built from three instances of the existing jk_ff sub-module, with J/K equations derived from the transition rules. The counters and shift register are behavioural registers.

## Test plan
- Reset: hold rst=0 → y, valid, busy and done are all 0. Assert rst=0 mid-SEND → all outputs drop to 0 at once, without waiting for a clock edge.
- cnt=1, start at edge 0 (default parameters) → y=1,0,1,1 in cycles 1–4 with valid=1 and busy=1; done=1 in cycle 5; IDLE in cycle 6.
- cnt=2 → bits in cycles 1–4; GAP in cycles 5–6 (busy=1, valid=0, y=0); bits in cycles 7–10; done in cycle 11.
- cnt=0 → done=1 in cycle 1; valid and busy remain 0 throughout.
- start pulsed during SEND → ignored, so the waveform is identical to a run without it. After reset release, start with cnt=1 → correct 1011 sequence from cycle 1.
- MOORE_SEQ_GEN_PARITY_EN defined, cnt=1 → 1,0,1,1 in cycles 1–4, parity y=1 with valid=1 in cycle 5, done in cycle 6.

Source files
------------

// File: rtl/moore_seq_gen_pkg.sv
// Shared constants for the Moore serial pattern generator: state encodings,
// default pattern parameters and the even-parity helper.
package moore_seq_pkg;

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_SEND   = 3'b001;
  localparam logic [2:0] S_PARITY = 3'b010;
  localparam logic [2:0] S_GAP    = 3'b011;
  localparam logic [2:0] S_DONE   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_SEND   = S_SEND,
    ST_PARITY = S_PARITY,
    ST_GAP    = S_GAP,
    ST_DONE   = S_DONE
  } state_t;

  localparam int          DEF_PAT_W   = 4;
  localparam logic [15:0] DEF_PATTERN = 16'h000B;
  localparam int          DEF_GAP     = 2;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [15:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/moore_seq_gen_jk_ff.sv
// JK flip-flop with asynchronous active-low reset; building block for the
// generator's state register.
module jk_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/moore_seq_gen.sv
// Moore serial pattern generator: sends PATTERN MSB first cnt times with GAP
// idle cycles between repetitions. Define MOORE_SEQ_GEN_PARITY_EN to append
// an even-parity bit after every repetition.
//
// Handshake: start is a level request sampled only while IDLE (busy=0,
// done=0); cnt is captured on the same edge. y is meaningful only while
// valid=1; busy covers SEND/PARITY/GAP and done pulses for one cycle after.
module moore_seq_gen
  import moore_seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               GAP     = DEF_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] cnt,
  output logic       y,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] LAST_BIT = 4'(PAT_W - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
`ifdef MOORE_SEQ_GEN_PARITY_EN
  localparam logic PARITY_BIT = even_parity(16'(PATTERN));
`endif

  logic [2:0]       state_bits;
  logic [2:0]       state_d_bits;
  state_t           state_q;
  state_t           state_d;
  logic [PAT_W-1:0] sreg_q, sreg_d;
  logic [3:0]       bit_q, bit_d;
  logic [3:0]       rep_q, rep_d;
  logic [3:0]       gap_q, gap_d;
  logic             pat_end;

  assign state_q      = state_t'(state_bits);
  assign state_d_bits = state_d;
  assign state_dbg    = state_bits;

  // State register: J sets a bit that must rise, K clears one that must fall.
  for (genvar i = 0; i < 3; i++) begin : g_state
    jk_ff u_jk (
      .clk   (clk),
      .rst_n (rst),
      .j     (~state_bits[i] &  state_d_bits[i]),
      .k     ( state_bits[i] & ~state_d_bits[i]),
      .q     (state_bits[i])
    );
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    pat_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cnt != 4'd0) begin
            state_d = ST_SEND;
            sreg_d  = PATTERN;
            rep_d   = cnt;
            bit_d   = 4'd0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        sreg_d = sreg_q << 1;
        bit_d  = bit_q + 4'd1;
        if (bit_q == LAST_BIT) begin
`ifdef MOORE_SEQ_GEN_PARITY_EN
          state_d = ST_PARITY;
`else
          pat_end = 1'b1;
`endif
        end
      end
`ifdef MOORE_SEQ_GEN_PARITY_EN
      ST_PARITY: pat_end = 1'b1;
`endif
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_SEND;
          sreg_d  = PATTERN;
          bit_d   = 4'd0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // End of one repetition: repeat (optionally via GAP) or finish.
    if (pat_end) begin
      rep_d = rep_q - 4'd1;
      if (rep_q > 4'd1) begin
        if (GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = 4'd0;
        end else begin
          state_d = ST_SEND;
          sreg_d  = PATTERN;
          bit_d   = 4'd0;
        end
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  // Datapath and outputs; outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      bit_q  <= 4'd0;
      rep_q  <= 4'd0;
      gap_q  <= 4'd0;
      y      <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      bit_q  <= bit_d;
      rep_q  <= rep_d;
      gap_q  <= gap_d;
      y      <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      case (state_d)
        ST_SEND: begin
          y     <= sreg_d[PAT_W-1];
          valid <= 1'b1;
          busy  <= 1'b1;
        end
`ifdef MOORE_SEQ_GEN_PARITY_EN
        ST_PARITY: begin
          y     <= PARITY_BIT;
          valid <= 1'b1;
          busy  <= 1'b1;
        end
`endif
        ST_GAP:  busy <= 1'b1;
        ST_DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_moore_seq_gen.sv
// Bench for moore_seq_gen: a trace model built from the pattern rules feeds
// an expected queue that is checked every cycle against {y,valid,busy,done}.
module tb_moore_seq_gen;

  localparam int               PAT_W   = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1011;
  localparam int               GAP     = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] cnt;
  logic       y, valid, busy, done;
  logic [2:0] state_dbg;

  logic [3:0] exp_q[$];
  int         checks;
  int         errors;
  logic       chk_en;

  moore_seq_gen #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .GAP     (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cnt       (cnt),
    .y         (y),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Trace model: entries are {y, valid, busy, done} per cycle after start.
  task automatic model_push(input int c);
    for (int r = 0; r < c; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({PATTERN[b], 3'b110});
`ifdef MOORE_SEQ_GEN_PARITY_EN
      exp_q.push_back({^PATTERN, 3'b110});
`endif
      if (r < c - 1)
        for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
  endtask

  task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // Scoreboard: every cycle, compare outputs with the model (idle when empty).
  initial begin
    logic [3:0] exp_v;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        check_val("cycle_cmp {y,valid,busy,done}", {y, valid, busy, done}, exp_v);
      end
    end
  end

  // Driver: start a transaction with count c; optionally pulse start again in
  // cycle pulse_at (counted from the acceptance edge) to prove it is ignored.
  task automatic run(input logic [3:0] c, input int pulse_at);
    int waited;
    @(negedge clk); #1;
    start = 1'b1;
    cnt   = c;
    model_push(int'(c));
    @(negedge clk); #1;
    start = 1'b0;
    cnt   = 4'($urandom_range(0, 15));
    if (pulse_at >= 2) begin
      repeat (pulse_at - 1) @(negedge clk);
      #1;
      start = 1'b1;
      cnt   = 4'd7;
      @(negedge clk); #1;
      start = 1'b0;
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst    = 1'b0;
    start  = 1'b0;
    cnt    = 4'd0;

    // Reset state, held low across edges
    repeat (3) @(negedge clk);
    check_val("reset_hold", {y, valid, busy, done}, 4'b0000);

    // Pin the model against hand-derived traces
    model_push(1);
    check_val("model_c1_bit0", exp_q[0], 4'b1110);
    check_val("model_c1_bit1", exp_q[1], 4'b0110);
    check_val("model_c1_bit3", exp_q[3], 4'b1110);
`ifdef MOORE_SEQ_GEN_PARITY_EN
    check_val("model_c1_parity", exp_q[4], 4'b1110);
    check_val("model_c1_done", exp_q[5], 4'b0001);
`else
    check_val("model_c1_done", exp_q[4], 4'b0001);
`endif
    exp_q.delete();
    model_push(2);
`ifdef MOORE_SEQ_GEN_PARITY_EN
    check_val("model_c2_gap", exp_q[5], 4'b0010);
    check_val("model_c2_bit2b", exp_q[7], 4'b1110);
    check_val("model_c2_done", exp_q[12], 4'b0001);
`else
    check_val("model_c2_gap0", exp_q[4], 4'b0010);
    check_val("model_c2_gap1", exp_q[5], 4'b0010);
    check_val("model_c2_bit1b", exp_q[7], 4'b0110);
    check_val("model_c2_done", exp_q[10], 4'b0001);
`endif
    exp_q.delete();

    @(negedge clk); #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    run(4'd1, 0);
    run(4'd2, 0);
    run(4'd0, 0);
    run(4'd1, 2);
    run(4'd2, 6);
    run(4'd1, 5);
    run(4'd3, 0);
    run(4'd15, 0);

    // Asynchronous reset in the middle of SEND
    @(negedge clk); #1;
    start = 1'b1;
    cnt   = 4'd3;
    model_push(3);
    @(negedge clk); #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    exp_q.delete();
    check_val("pre_reset_busy", {busy, valid}, 2'b11);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_reset_drop", {y, valid, busy, done}, 4'b0000);
    @(negedge clk);
    check_val("async_reset_hold", {y, valid, busy, done}, 4'b0000);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;
    run(4'd1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
